// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings, FSM states and the EX control bundle for the ID/EX control path.
package ctrl_pkg;
    localparam logic [3:0] ALU_MOV = 4'b0001, ALU_MVN = 4'b1001, ALU_ADD = 4'b0010,
                           ALU_ADC = 4'b0011, ALU_SUB = 4'b0100, ALU_SBC = 4'b0101,
                           ALU_AND = 4'b0110, ALU_ORR = 4'b0111, ALU_EOR = 4'b1000;
    localparam logic [1:0] MODE_DP = 2'b00, MODE_LS = 2'b01, MODE_BR = 2'b10, MODE_BLK = 2'b11;
    localparam logic [3:0] OP_MOV = 4'b1101, OP_MVN = 4'b1111, OP_ADD = 4'b0100, OP_ADC = 4'b0101,
                           OP_SUB = 4'b0010, OP_SBC = 4'b0110, OP_AND = 4'b0000, OP_ORR = 4'b1100,
                           OP_EOR = 4'b0001, OP_CMP = 4'b1010, OP_TST = 4'b1000;
    typedef enum logic {IDLE, BLOCK} state_t;
    typedef struct packed {
        logic [3:0] alu_command;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       branch;
        logic       status_en;
    } ctrl_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational mode/op_code/s to EX control bundle.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] op_code,
    input  logic       s,
    output ctrl_t      ctrl
);
    logic [3:0] dp_alu;
    logic       plain;
    logic       test;
    always_comb begin
        dp_alu = '0;
        plain = 1'b1;
        test = 1'b0;
        case (op_code)
            OP_MOV: dp_alu = ALU_MOV;
            OP_MVN: dp_alu = ALU_MVN;
            OP_ADD: dp_alu = ALU_ADD;
            OP_ADC: dp_alu = ALU_ADC;
            OP_SUB: dp_alu = ALU_SUB;
            OP_SBC: dp_alu = ALU_SBC;
            OP_AND: dp_alu = ALU_AND;
            OP_ORR: dp_alu = ALU_ORR;
            OP_EOR: dp_alu = ALU_EOR;
            OP_CMP: begin dp_alu = ALU_SUB; plain = 1'b0; test = 1'b1; end
            OP_TST: begin dp_alu = ALU_AND; plain = 1'b0; test = 1'b1; end
            default: plain = 1'b0;
        endcase
        ctrl = '0;
        case (mode)
            MODE_DP: begin
                ctrl.alu_command = dp_alu;
                ctrl.wb_en = plain;
                ctrl.status_en = plain ? s : test;
            end
            MODE_BR: ctrl.branch = 1'b1;
            // single and block transfers share the address-add datapath
            default: begin
                ctrl.alu_command = ALU_ADD;
                ctrl.mem_read = s;
                ctrl.wb_en = s;
                ctrl.mem_write = !s;
            end
        endcase
    end
endmodule

// File: rtl/block_ctrl_sequencer.sv
// block_ctrl_sequencer: registered ID/EX control with squash, stall/flush and an LDM/STM beat sequencer.
module block_ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int REG_W = $clog2(NREGS),
    parameter int OFF_W = $clog2(NREGS) + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [3:0]       op_code,
    input  logic             s,
    input  logic             up,
    input  logic             wback,
    input  logic [NREGS-1:0] reg_list,
    input  logic             cond_pass,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [3:0]       alu_command,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_en,
    output logic             branch,
    output logic             status_en,
    output logic [REG_W-1:0] ls_reg,
    output logic [OFF_W-1:0] ls_offset,
    output logic             base_wb_en,
    output logic [OFF_W-1:0] base_delta,
    output logic             last
);
    localparam int CNT_W = REG_W + 1;
    state_t           state;
    ctrl_t            dec, beat_ctrl, ctrl_q;
    logic [NREGS-1:0] rem_q, cur_list, low_oh;
    logic [REG_W-1:0] k_q, cur_k, low_idx;
    logic [CNT_W-1:0] pop;
    logic [OFF_W-1:0] pop4_q, cur_pop4, offset, delta;
    logic             s_q, up_q, wback_q;
    logic             idle, cur_s, cur_up, cur_wback, single, acc, is_blk;
    assign idle = state == IDLE;
    assign in_ready = idle && !stall;
    assign cur_list = idle ? reg_list : rem_q;
    assign cur_s = idle ? s : s_q;
    assign cur_up = idle ? up : up_q;
    assign cur_wback = idle ? wback : wback_q;
    assign cur_k = idle ? '0 : k_q;
    assign cur_pop4 = idle ? {pop, 2'b00} : pop4_q;
    assign low_oh = cur_list & (~cur_list + NREGS'(1));
    assign single = (cur_list & (cur_list - NREGS'(1))) == '0;
    assign offset = {1'b0, cur_k, 2'b00} - (cur_up ? '0 : cur_pop4);
    assign delta = cur_up ? cur_pop4 : -cur_pop4;
    assign acc = idle && in_valid;
    assign is_blk = !idle || (acc && mode == MODE_BLK && cond_pass && reg_list != '0);
    assign beat_ctrl = (idle && (!cond_pass || (mode == MODE_BLK && reg_list == '0))) ? '0 : dec;
    always_comb begin
        low_idx = '0;
        pop = '0;
        for (int i = NREGS - 1; i >= 0; i--) if (cur_list[i]) low_idx = REG_W'(i);
        for (int i = 0; i < NREGS; i++) pop = pop + CNT_W'(reg_list[i]);
    end
    ctrl_decode u_decode (
        .mode    (idle ? mode : MODE_BLK),
        .op_code (op_code),
        .s       (cur_s),
        .ctrl    (dec)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ctrl_q <= '0;
            out_valid <= 1'b0;
            ls_reg <= '0;
            ls_offset <= '0;
            base_wb_en <= 1'b0;
            base_delta <= '0;
            last <= 1'b0;
            rem_q <= '0;
            k_q <= '0;
            pop4_q <= '0;
            s_q <= 1'b0;
            up_q <= 1'b0;
            wback_q <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            ctrl_q <= '0;
            out_valid <= 1'b0;
            ls_reg <= '0;
            ls_offset <= '0;
            base_wb_en <= 1'b0;
            base_delta <= '0;
            last <= 1'b0;
        end else if (!stall) begin
            out_valid <= acc || !idle;
            ctrl_q <= (acc || !idle) ? beat_ctrl : '0;
            ls_reg <= is_blk ? low_idx : '0;
            ls_offset <= is_blk ? offset : '0;
            base_delta <= is_blk ? delta : '0;
            base_wb_en <= is_blk && cur_wback && single;
            last <= (acc || !idle) && (!is_blk || single);
            if (is_blk) begin
                rem_q <= cur_list & ~low_oh;
                k_q <= cur_k + REG_W'(1);
                state <= single ? IDLE : BLOCK;
            end
            if (idle) begin
                s_q <= s;
                up_q <= up;
                wback_q <= wback;
                pop4_q <= {pop, 2'b00};
            end
        end
    end
    assign {alu_command, mem_read, mem_write, wb_en, branch, status_en} = ctrl_q;
endmodule

// File: tb/tb_block_ctrl_sequencer.sv
// tb_block_ctrl_sequencer: scoreboard bench; expected beats queued at issue, popped on each fresh out_valid.
module tb_block_ctrl_sequencer;
    typedef struct packed {
        logic [3:0] alu;
        logic       mr, mw, wb, br, st;
        logic [3:0] r;
        logic [6:0] off;
        logic       bwb;
        logic [6:0] delta;
        logic       last;
    } exp_t;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [1:0]  mode = '0;
    logic [3:0]  op_code = '0;
    logic        s = 1'b0, up = 1'b0, wback = 1'b0, cond_pass = 1'b1, stall = 1'b0, flush = 1'b0;
    logic [15:0] reg_list = '0;
    logic        out_valid, mem_read, mem_write, wb_en, branch, status_en, base_wb_en, last;
    logic [3:0]  alu_command, ls_reg;
    logic [6:0]  ls_offset, base_delta;
    logic        fresh = 1'b0;
    exp_t        q[$];
    exp_t        got, e;
    int          compared = 0, mismatched = 0;
    block_ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .op_code(op_code), .s(s), .up(up), .wback(wback), .reg_list(reg_list),
        .cond_pass(cond_pass), .stall(stall), .flush(flush), .out_valid(out_valid),
        .alu_command(alu_command), .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en),
        .branch(branch), .status_en(status_en), .ls_reg(ls_reg), .ls_offset(ls_offset),
        .base_wb_en(base_wb_en), .base_delta(base_delta), .last(last)
    );
    always #5 clk = ~clk;
    assign got = '{alu_command, mem_read, mem_write, wb_en, branch, status_en, ls_reg, ls_offset,
                   base_wb_en, base_delta, last};
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask
    function automatic exp_t blk(input logic [15:0] l, input int k, input bit u, input bit ld, input bit w);
        int n = 0, c = 0, idx = 0;
        exp_t x;
        for (int i = 0; i < 16; i++) if (l[i]) n++;
        for (int i = 0; i < 16; i++) if (l[i]) begin if (c == k) idx = i; c++; end
        x = '0;
        x.alu = 4'b0010;
        x.mr = ld;
        x.wb = ld;
        x.mw = !ld;
        x.r = 4'(idx);
        x.off = u ? 7'(4 * k) : 7'(4 * k - 4 * n);
        x.last = k == n - 1;
        x.bwb = w && x.last;
        x.delta = u ? 7'(4 * n) : 7'(-4 * n);
        return x;
    endfunction
    function automatic exp_t single_op(input logic [3:0] alu, input bit wb, input bit br, input bit st);
        exp_t x = '0;
        x.alu = alu;
        x.wb = wb;
        x.br = br;
        x.st = st;
        x.last = 1'b1;
        return x;
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [1:0] m, input logic [3:0] op, input bit sv, input bit u,
                         input bit w, input logic [15:0] l, input bit cp);
        int t = 0;
        while (!in_ready && t < 50) begin step(); t++; end
        if (t == 50) chk("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; mode = m; op_code = op; s = sv; up = u; wback = w; reg_list = l; cond_pass = cp;
        step();
        in_valid = 1'b0;
    endtask
    always @(posedge clk) fresh <= !stall;
    always @(negedge clk) begin
        if (rst_n && out_valid && fresh) begin
            if (q.size() == 0) chk("sb_underflow", 32'(q.size()), 32'd1);
            else begin
                e = q.pop_front();
                chk("beat", 32'(got), 32'(e));
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        #2 rst_n = 1'b0;
        step(); step();
        chk("rst_outs", {3'b0, out_valid, 28'(got)}, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        q.push_back(single_op(4'b0010, 1'b1, 1'b0, 1'b1));
        issue(2'b00, 4'b0100, 1'b1, 0, 0, '0, 1'b1);
        q.push_back(single_op(4'b0100, 1'b0, 1'b0, 1'b1));
        issue(2'b00, 4'b1010, 1'b0, 0, 0, '0, 1'b1);
        q.push_back(single_op(4'b0000, 1'b0, 1'b0, 1'b0));
        issue(2'b00, 4'b1010, 1'b0, 0, 0, '0, 1'b0);
        q.push_back(single_op(4'b1000, 1'b1, 1'b0, 1'b0));
        issue(2'b00, 4'b0001, 1'b0, 0, 0, '0, 1'b1);
        for (int k = 0; k < 3; k++) q.push_back(blk(16'h8012, k, 1, 1, 1));
        issue(2'b11, 4'b0000, 1'b1, 1, 1, 16'h8012, 1'b1);
        chk("ldm_busy0", 32'(in_ready), 32'd0);
        step();
        chk("ldm_busy1", 32'(in_ready), 32'd0);
        step();
        chk("ldm_free", 32'(in_ready), 32'd1);
        chk("ldm_bwb", 32'(base_wb_en), 32'd1);
        chk("ldm_delta", 32'(base_delta), 32'd12);
        for (int k = 0; k < 2; k++) q.push_back(blk(16'h0006, k, 0, 0, 0));
        issue(2'b11, 4'b0000, 1'b0, 0, 0, 16'h0006, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_reg", 32'(ls_reg), 32'd1);
            chk("hold_off", 32'(ls_offset), 32'h78);
            chk("hold_mw", 32'(mem_write), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        stall = 1'b0;
        step();
        chk("stm_reg2", 32'(ls_reg), 32'd2);
        chk("stm_off2", 32'(ls_offset), 32'h7c);
        step();
        for (int k = 0; k < 3; k++) q.push_back(blk(16'h00FF, k, 1, 1, 1));
        issue(2'b11, 4'b0000, 1'b1, 1, 1, 16'h00FF, 1'b1);
        step();
        step();
        chk("pre_flush_reg", 32'(ls_reg), 32'd2);
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        #1;
        chk("flush_outs", {3'b0, out_valid, 28'(got)}, 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        step();
        chk("flush_quiet", 32'(out_valid), 32'd0);
        chk("flush_nobwb", 32'(base_wb_en), 32'd0);
        q.push_back(single_op(4'b0000, 1'b0, 1'b0, 1'b0));
        issue(2'b11, 4'b0000, 1'b1, 1, 1, 16'h0000, 1'b1);
        q.push_back(single_op(4'b0000, 1'b0, 1'b1, 1'b0));
        issue(2'b10, 4'b0000, 1'b0, 0, 0, '0, 1'b1);
        q.push_back(single_op(4'b0000, 1'b0, 1'b0, 1'b0));
        issue(2'b11, 4'b0000, 1'b1, 1, 1, 16'h0F0F, 1'b0);
        chk("squash_ready", 32'(in_ready), 32'd1);
        step();
        step();
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
